// File: rtl/sll.sv
// 32-bit logical left shifter: five cascaded combinational barrel stages
// (16/8/4/2/1) feeding a single registered output.

module sll_stage #(
    parameter int DIST = 1
) (
    input  logic [31:0] i_a,
    input  logic        i_sel,
    output logic [31:0] o_y
);
    assign o_y = i_sel ? {i_a[31-DIST:0], {DIST{1'b0}}} : i_a;
endmodule

module sll (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data,
    input  logic [4:0]  shiftamt,
    output logic [31:0] out
);
    localparam int STAGES = 5;

    logic [31:0] w_stage [0:STAGES];
    logic [31:0] r_out;

    assign w_stage[0] = data;

    // Stage g shifts by 16>>g and is selected by shiftamt[4-g].
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        sll_stage #(.DIST(16 >> g)) u_stage (
            .i_a  (w_stage[g]),
            .i_sel(shiftamt[STAGES-1-g]),
            .o_y  (w_stage[g+1])
        );
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_out <= 32'h0;
        else        r_out <= w_stage[STAGES];
    end

    assign out = r_out;
endmodule

// File: tb/tb_sll.sv
// Directed bench for sll: reset behaviour, spec vectors, boundaries and a
// full sweep of shift amounts against random data.

module tb_sll;
    logic        clock;
    logic        reset;
    logic [31:0] data;
    logic [4:0]  shiftamt;
    logic [31:0] out;

    int checks   = 0;
    int failures = 0;

    sll dut (
        .clock   (clock),
        .reset   (reset),
        .data    (data),
        .shiftamt(shiftamt),
        .out     (out)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] exp);
        checks++;
        assert (out === exp) else begin
            failures++;
            $error("FAIL %s out=%h expected=%h", tag, out, exp);
        end
    endtask

    task automatic step(input logic [31:0] d, input logic [4:0] s,
                        input string tag, input logic [31:0] exp);
        data     = d;
        shiftamt = s;
        @(posedge clock);
        #1 chk(tag, exp);
    endtask

    initial begin
        logic [31:0] rd;
        reset    = 1'b1;
        data     = 32'h0;
        shiftamt = 5'd0;

        // Asynchronous assertion before any clock edge
        #1 reset = 1'b0;
        #1 chk("rst_async", 32'h0);
        data     = 32'hFFFFFFFF;
        shiftamt = 5'd3;
        repeat (2) @(posedge clock);
        #1 chk("rst_hold", 32'h0);
        @(negedge clock);
        reset = 1'b1;
        #1 chk("rst_release_no_edge", 32'h0);

        step(32'd300,       5'd17, "req24",       32'h02580000);
        step(32'hA5A5A5A5,  5'd5,  "req25",       32'hB4B4B4A0);

        // Inputs changing between edges must not reach out
        data     = 32'h00000001;
        shiftamt = 5'd4;
        #2 chk("hold_between_edges", 32'hB4B4B4A0);
        @(posedge clock);
        #1 chk("after_mid_change", 32'h00000010);

        step(32'hFFFFFFFF,  5'd0,  "amt0_ones",   32'hFFFFFFFF);
        step(32'hFFFFFFFF,  5'd31, "amt31_ones",  32'h80000000);
        step(32'h00000001,  5'd16, "one_by16",    32'h00010000);
        step(32'h7FFFFFFE,  5'd31, "amt31_lsb0",  32'h00000000);
        step(32'h80000001,  5'd1,  "no_sign_ext", 32'h00000002);
        step(32'h00000000,  5'd13, "zero_data",   32'h00000000);
        step(32'hDEADBEEF,  5'd0,  "amt0_pass",   32'hDEADBEEF);
        step(32'h0000FFFF,  5'd12, "amt12",       32'hFFFF000);

        // Back-to-back edges, one result per cycle
        step(32'h12345678,  5'd2,  "b2b_edge1",   32'h48D159E0);
        step(32'hABCDEF01,  5'd8,  "b2b_edge2",   32'hCDEF0100);

        // Reset mid-operation
        @(negedge clock);
        data     = 32'h00000003;
        shiftamt = 5'd1;
        reset    = 1'b0;
        #1 chk("rst_mid_async", 32'h0);
        repeat (2) @(posedge clock);
        #1 chk("rst_mid_hold", 32'h0);
        @(negedge clock);
        reset = 1'b1;
        #1 chk("rst_mid_release", 32'h0);
        @(posedge clock);
        #1 chk("first_edge_after_rst", 32'h00000006);

        // Every shift amount against random data
        for (int s = 0; s < 32; s++) begin
            rd = $urandom;
            step(rd, 5'(s), $sformatf("sweep_amt%0d", s), rd << s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
